// File: rtl/mem_pkg.sv
// Shared types and constants for the banked memory responder.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int BANK_W = 3;

    // Width of the latency and recovery counters; holds 0..15.
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/bank_recovery_timer.sv
// Per-bank recovery countdown: load on access completion, count down to zero.
// Latency: busy asserts the cycle after load, clears RECOVERY cycles later.
// Backpressure: none; busy is advisory to the request FSM.
module bank_recovery_timer #(
    parameter int CNT_W = mem_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_busy
);

    logic [CNT_W-1:0] r_cnt;

    // Load wins over decrement; otherwise count down and saturate at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/mem_bank_responder.sv
// Banked memory responder: one access at a time, fixed latency, per-bank recovery.
// Latency: done pulses ACCESS_LAT cycles after accept, plus any recovery stall.
// Backpressure: ready low from accept through the done cycle; req ignored then.
module mem_bank_responder #(
    parameter int DATA_W     = mem_pkg::DATA_W,
    parameter int ADDR_W     = mem_pkg::ADDR_W,
    parameter int BANK_W     = mem_pkg::BANK_W,
    parameter int ACCESS_LAT = 2,
    parameter int RECOVERY   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BANK_W-1:0] bank,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              ready,
    output logic              done
);

    import mem_pkg::*;

    localparam int NBANK = 1 << BANK_W;
    localparam int DEPTH = 1 << (BANK_W + ADDR_W);

    state_t                    r_state;
    state_t                    w_next;

    logic                      r_rw;
    logic [ADDR_W-1:0]         r_addr;
    logic [BANK_W-1:0]         r_bank;
    logic [DATA_W-1:0]         r_din;
    logic [CNT_W-1:0]          r_lat;

    logic [NBANK-1:0]          w_busy;
    logic [NBANK-1:0]          w_load;
    logic                      w_accept;
    logic                      w_access_go;
    logic                      w_enter_access;
    logic                      w_ready_nxt;
    logic                      w_done_nxt;
    logic [BANK_W+ADDR_W-1:0]  w_idx;

    logic [DATA_W-1:0]         r_mem [0:DEPTH-1];

    assign w_accept       = (r_state == IDLE) && req;
    assign w_access_go    = (r_state == ACCESS) && (r_lat == '0);
    assign w_enter_access = (w_next == ACCESS) && (r_state != ACCESS);
    assign w_idx          = {r_bank, r_addr};

    // One recovery timer per bank; a bank is reloaded only on its own DONE cycle.
    for (genvar g = 0; g < NBANK; g++) begin : g_bank
        assign w_load[g] = (r_state == DONE) && (r_bank == BANK_W'(g));

        bank_recovery_timer #(
            .CNT_W (CNT_W)
        ) u_timer (
            .clk        (clk),
            .reset      (reset),
            .i_load     (w_load[g]),
            .i_load_val (CNT_W'(RECOVERY)),
            .o_busy     (w_busy[g])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: stall in WAIT while the addressed bank is still recovering.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_next = w_busy[bank] ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (!w_busy[r_bank]) begin
                    w_next = ACCESS;
                end
            end
            ACCESS: begin
                if (r_lat == '0) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Output decode from the next state so ready/done can be registered.
    always_comb begin
        w_ready_nxt = (w_next == IDLE);
        w_done_nxt  = (w_next == DONE);
    end

    // Registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready <= 1'b1;
            done  <= 1'b0;
        end else begin
            ready <= w_ready_nxt;
            done  <= w_done_nxt;
        end
    end

    // Capture the request on accept; the latched copy drives the whole access.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rw   <= 1'b0;
            r_addr <= '0;
            r_bank <= '0;
            r_din  <= '0;
        end else if (w_accept) begin
            r_rw   <= rw;
            r_addr <= addr;
            r_bank <= bank;
            r_din  <= din;
        end
    end

    // Access latency counter: loaded on entry to ACCESS, counts down to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lat <= '0;
        end else if (w_enter_access) begin
            r_lat <= CNT_W'(ACCESS_LAT - 1);
        end else if ((r_state == ACCESS) && (r_lat != '0)) begin
            r_lat <= r_lat - 1'b1;
        end
    end

    // Read data register: only a completing read updates it, writes leave it held.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= '0;
        end else if (w_access_go && !r_rw) begin
            dout <= r_mem[w_idx];
        end
    end

    // Storage is not reset; a reset on the completion edge drops the write.
    always_ff @(posedge clk) begin
        if (!reset && w_access_go && r_rw) begin
            r_mem[w_idx] <= r_din;
        end
    end

endmodule

// File: tb/tb_mem_bank_responder.sv
module tb_mem_bank_responder;

    localparam int LAT = 2;
    localparam int REC = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        rw;
    logic [5:0]  addr;
    logic [2:0]  bank;
    logic [31:0] din;
    logic [31:0] dout;
    logic        ready;
    logic        done;

    mem_bank_responder #(
        .DATA_W     (32),
        .ADDR_W     (6),
        .BANK_W     (3),
        .ACCESS_LAT (LAT),
        .RECOVERY   (REC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .rw    (rw),
        .addr  (addr),
        .bank  (bank),
        .din   (din),
        .dout  (dout),
        .ready (ready),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Absolute edge number: after the k-th rising edge edge_cnt == k.
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int          done_edge;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_mem [8][64];
    int          bank_free [8];
    logic [31:0] last_read;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference timing: an access starts at its accept edge or when the bank
    // frees (two edges after DONE entry plus the recovery time), whichever is later.
    task automatic model_accept(input int n, input logic w, input int b, input int a, input logic [31:0] d);
        exp_t e;
        int   s;
        s = (n > bank_free[b]) ? n : bank_free[b];
        e.done_edge = s + LAT;
        bank_free[b] = e.done_edge + REC + 2;
        if (w) begin
            m_mem[b][a] = d;
        end else begin
            last_read = m_mem[b][a];
        end
        e.data = last_read;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) bank_free[i] = 0;
        last_read = 32'h0;
    endtask

    // Present a request (req stays high afterwards) and wait for it to be taken.
    task automatic issue(input logic w, input int b, input int a, input logic [31:0] d);
        int budget;
        @(negedge clk);
        req  = 1'b1;
        rw   = w;
        bank = 3'(b);
        addr = 6'(a);
        din  = d;
        budget = 60;
        while (!ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            req = 1'b0;
        end else begin
            model_accept(edge_cnt + 1, w, b, a, d);
            @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain();
        int budget;
        budget = 300;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding access.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_cycle", 32'(edge_cnt), 32'(e.done_edge));
                check("dout", dout, e.data);
                check("ready_during_done", {31'd0, ready}, 32'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d outstanding", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req   = 1'b0;
        rw    = 1'b0;
        addr  = '0;
        bank  = '0;
        din   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_dout", dout, 32'd0);
        reset = 1'b0;

        // Directed: write then read the same location in bank 3.
        issue(1'b1, 3, 5, 32'hDEADBEEF);
        issue(1'b0, 3, 5, 32'h0);
        idle(8);

        // Fill every location, bank varying fastest so no stalls occur.
        for (int a = 0; a < 64; a++)
            for (int b = 0; b < 8; b++)
                issue(1'b1, b, a, $urandom);
        idle(8);

        // Same-bank back-to-back forces the recovery stall.
        issue(1'b1, 1, 0, 32'hA5A5_0001);
        issue(1'b0, 1, 0, 32'h0);
        idle(8);

        // Different bank back-to-back: no stall.
        issue(1'b1, 1, 9, 32'h0BAD_F00D);
        issue(1'b0, 2, 9, 32'h0);
        idle(8);

        // req held high throughout, alternating banks 0 and 4.
        for (int i = 0; i < 12; i++)
            issue(i[0], (i % 2 == 0) ? 0 : 4, i, $urandom);
        idle(8);

        // Read then write: dout must hold the read value across the write.
        issue(1'b0, 6, 17, 32'h0);
        issue(1'b1, 5, 18, 32'h7777_8888);
        idle(4);
        issue(1'b1, 6, 19, 32'h1111_2222);
        idle(8);

        // Randomised traffic with random gaps.
        for (int i = 0; i < 250; i++) begin
            issue(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 63), $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
        end
        idle(2);
        wait_drain();

        // Reset during ACCESS of a write: write is dropped, outputs reset.
        idle(8);
        @(negedge clk);
        req  = 1'b1;
        rw   = 1'b1;
        bank = 3'd7;
        addr = 6'd63;
        din  = 32'h0000_1234;
        check("pre_abort_ready", {31'd0, ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req   = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_dout", dout, 32'd0);
        reset = 1'b0;
        model_reset();
        issue(1'b0, 7, 63, 32'h0);
        idle(2);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
